// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch block.
// Holds the FSM state encoding, the 32-bit word type and the wait-counter width.
package imem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/imem_array.sv
// Word-organised instruction storage.
// Provides one byte-strobed write port and N_PORTS combinational read ports at consecutive words.
module imem_array
  import imem_pkg::*;
#(
  parameter int AW      = 11,
  parameter int N_PORTS = 1
) (
  input  logic                      clk_i,
  input  logic                      wr_en_i,
  input  logic [AW-1:0]             wr_idx_i,
  input  word_t                     wr_data_i,
  input  logic [3:0]                wr_strb_i,
  input  logic [AW-1:0]             rd_idx_i,
  output logic [WORD_W*N_PORTS-1:0] rd_data_o
);

  localparam int DEPTH = 2 ** AW;

  word_t mem [DEPTH];

  // Storage has no reset so that program contents survive a block reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_i[b]) begin
          mem[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  // The index sum is AW bits wide, so a fetch past the top word wraps to word 0.
  for (genvar k = 0; k < N_PORTS; k++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx = rd_idx_i + AW'(k);
    assign rd_data_o[WORD_W*k +: WORD_W] = mem[idx];
  end

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch front end: request/response handshake, fixed wait states, multi-word reads.
// Define IMEM_FETCH_ERR_EN to flag misaligned requests with rsp_err_o instead of ignoring addr[1:0].
module imem_fetch
  import imem_pkg::*;
#(
  parameter int IMEM_W   = 13,
  parameter int WAIT_CYC = 1,
  parameter int FETCH_N  = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [IMEM_W-1:0]         req_addr_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [WORD_W*FETCH_N-1:0] rsp_data_o,
  output logic                      rsp_err_o,
  input  logic                      wr_en_i,
  input  logic [IMEM_W-1:0]         wr_addr_i,
  input  word_t                     wr_data_i,
  input  logic [3:0]                wr_strb_i
);

  localparam int AW = IMEM_W - 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [IMEM_W-1:0]          addr_q;
  logic                       req_ready_q;
  logic                       rsp_valid_q;
  logic                       rsp_err_q;
  logic [WORD_W*FETCH_N-1:0]  rsp_data_q;

  logic                       accept;
  logic                       wr_commit;
  logic                       misaligned;
  logic [IMEM_W-1:0]          rd_addr;
  logic [WORD_W*FETCH_N-1:0]  rd_data;
  logic [WORD_W*FETCH_N-1:0]  capture_data;

  assign accept    = req_valid_i & req_ready_q;
  assign wr_commit = wr_en_i & rst_ni;

  // With zero wait states the capture happens on the accept edge, so the live address is read.
  assign rd_addr = (state == IDLE) ? req_addr_i : addr_q;

`ifdef IMEM_FETCH_ERR_EN
  assign misaligned = |rd_addr[1:0];
  logic unused_lsb;
  assign unused_lsb = ^wr_addr_i[1:0];
`else
  assign misaligned = 1'b0;
  logic unused_lsb;
  assign unused_lsb = ^{wr_addr_i[1:0], rd_addr[1:0]};
`endif

  assign capture_data = misaligned ? '0 : rd_data;

  imem_array #(
    .AW      (AW),
    .N_PORTS (FETCH_N)
  ) u_array (
    .clk_i     (clk_i),
    .wr_en_i   (wr_commit),
    .wr_idx_i  (wr_addr_i[IMEM_W-1:2]),
    .wr_data_i (wr_data_i),
    .wr_strb_i (wr_strb_i),
    .rd_idx_i  (rd_addr[IMEM_W-1:2]),
    .rd_data_o (rd_data)
  );

  // Response registers are cleared whenever no response is pending, so outputs read 0 outside RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q      <= req_addr_i;
            req_ready_q <= 1'b0;
            if (WAIT_CYC == 0) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= misaligned;
              rsp_data_q  <= capture_data;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= misaligned;
            rsp_data_q  <= capture_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= '0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Directed testbench for imem_fetch: a 3-wait-state 4-word instance and a 0-wait 1-word instance.
// Expectations for misaligned requests follow IMEM_FETCH_ERR_EN.
module tb_imem_fetch;

  localparam int IMEM_W = 13;
  localparam int A_WAIT = 3;
  localparam int A_N    = 4;

  typedef struct {
    logic [IMEM_W-1:0] addr;
    logic [127:0]      data;
    logic              err;
  } vec_t;

  logic clk;
  logic rst_n;

  logic              a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err, a_wr_en;
  logic [IMEM_W-1:0] a_req_addr, a_wr_addr;
  logic [127:0]      a_rsp_data;
  logic [31:0]       a_wr_data;
  logic [3:0]        a_wr_strb;

  logic              b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_wr_en;
  logic [IMEM_W-1:0] b_req_addr, b_wr_addr;
  logic [31:0]       b_rsp_data;
  logic [31:0]       b_wr_data;
  logic [3:0]        b_wr_strb;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[8];

  imem_fetch #(.IMEM_W(IMEM_W), .WAIT_CYC(A_WAIT), .FETCH_N(A_N)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_addr_i(a_req_addr),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_data_o(a_rsp_data),
    .rsp_err_o(a_rsp_err),
    .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data), .wr_strb_i(a_wr_strb)
  );

  imem_fetch #(.IMEM_W(IMEM_W), .WAIT_CYC(0), .FETCH_N(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(b_req_addr),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_data_o(b_rsp_data),
    .rsp_err_o(b_rsp_err),
    .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data), .wr_strb_i(b_wr_strb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic a_write(input logic [IMEM_W-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
    a_wr_addr = addr; a_wr_data = data; a_wr_strb = strb; a_wr_en = 1'b1;
    @(posedge clk); #1;
    a_wr_en = 1'b0; a_wr_strb = 4'h0;
  endtask

  task automatic b_write(input logic [IMEM_W-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
    b_wr_addr = addr; b_wr_data = data; b_wr_strb = strb; b_wr_en = 1'b1;
    @(posedge clk); #1;
    b_wr_en = 1'b0; b_wr_strb = 4'h0;
  endtask

  // One complete request on instance A: accept, measure latency, compare, then hand the response off.
  task automatic applyStimulus(input vec_t v, input int idx);
    int lat;
    a_req_addr  = v.addr;
    a_req_valid = 1'b1;
    @(negedge clk);
    checkOutput($sformatf("v%0d req_ready", idx), 128'(a_req_ready), 128'd1);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!a_rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput($sformatf("v%0d latency", idx), 128'(lat), 128'(1 + A_WAIT));
    if (a_rsp_valid) begin
      checkOutput($sformatf("v%0d data", idx), a_rsp_data, v.data);
      checkOutput($sformatf("v%0d err", idx), 128'(a_rsp_err), 128'(v.err));
    end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_rsp_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{13'h0000, {32'hA3A3000C, 32'hA2A20008, 32'hA1A10004, 32'hA0A00000}, 1'b0};
    vecs[1] = '{13'h0004, {32'hDEADBEEF, 32'hA3A3000C, 32'hA2A20008, 32'hA1A10004}, 1'b0};
    vecs[2] = '{13'h0010, {32'h2222001C, 32'h11110018, 32'h0BADF00D, 32'hDEADBEEF}, 1'b0};
    vecs[3] = '{13'h1FF8, {32'hA1A10004, 32'hA0A00000, 32'hCAFE1FFC, 32'hCAFE1FF8}, 1'b0};
    vecs[4] = '{13'h1FFC, {32'hA2A20008, 32'hA1A10004, 32'hA0A00000, 32'hCAFE1FFC}, 1'b0};
`ifdef IMEM_FETCH_ERR_EN
    vecs[5] = '{13'h0006, 128'd0, 1'b1};
`else
    vecs[5] = '{13'h0006, {32'hDEADBEEF, 32'hA3A3000C, 32'hA2A20008, 32'hA1A10004}, 1'b0};
`endif
    vecs[6] = '{13'h000C, {32'h11110018, 32'h0BADF00D, 32'hDEADBEEF, 32'hA3A3000C}, 1'b0};
    vecs[7] = '{13'h0020, {32'h2C2C2C2C, 32'h28282828, 32'h24242424, 32'h1122AB44}, 1'b0};

    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_addr = '0; a_rsp_ready = 1'b0;
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_wr_strb = '0;
    b_req_valid = 1'b0; b_req_addr = '0; b_rsp_ready = 1'b0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_strb = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset a_rsp_valid", 128'(a_rsp_valid), 128'd0);
    checkOutput("reset a_rsp_data", a_rsp_data, 128'd0);
    checkOutput("reset a_rsp_err", 128'(a_rsp_err), 128'd0);
    checkOutput("reset b_rsp_valid", 128'(b_rsp_valid), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset a_req_ready", 128'(a_req_ready), 128'd1);
    checkOutput("post-reset b_req_ready", 128'(b_req_ready), 128'd1);
    @(posedge clk); #1;

    a_write(13'h0000, 32'hA0A00000, 4'hF);
    a_write(13'h0004, 32'hA1A10004, 4'hF);
    a_write(13'h0008, 32'hA2A20008, 4'hF);
    a_write(13'h000C, 32'hA3A3000C, 4'hF);
    a_write(13'h0010, 32'hDEADBEEF, 4'hF);
    a_write(13'h0014, 32'h0BADF00D, 4'hF);
    a_write(13'h0018, 32'h11110018, 4'hF);
    a_write(13'h001C, 32'h2222001C, 4'hF);
    a_write(13'h1FF8, 32'hCAFE1FF8, 4'hF);
    a_write(13'h1FFC, 32'hCAFE1FFC, 4'hF);
    a_write(13'h0020, 32'h11223344, 4'hF);
    a_write(13'h0024, 32'h24242424, 4'hF);
    a_write(13'h0028, 32'h28282828, 4'hF);
    a_write(13'h002C, 32'h2C2C2C2C, 4'hF);
    a_write(13'h0022, 32'h0000AB00, 4'b0010);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Held response: valid from T+4 through T+7 with stable data, ready again at T+8.
    a_req_addr  = 13'h0010;
    a_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checkOutput($sformatf("hold T+%0d rsp_valid", c), 128'(a_rsp_valid), (c >= 4) ? 128'd1 : 128'd0);
      checkOutput($sformatf("hold T+%0d rsp_data", c), a_rsp_data, (c >= 4) ? vecs[2].data : 128'd0);
      checkOutput($sformatf("hold T+%0d req_ready", c), 128'(a_req_ready), 128'd0);
      if (c == 7) a_rsp_ready = 1'b1;
      @(posedge clk); #1;
    end
    a_rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("hold T+8 req_ready", 128'(a_req_ready), 128'd1);
    checkOutput("hold T+8 rsp_valid", 128'(a_rsp_valid), 128'd0);
    checkOutput("hold T+8 rsp_data", a_rsp_data, 128'd0);
    @(posedge clk); #1;

    // Reset during WAIT: the request vanishes, a write under reset is dropped, memory survives.
    a_req_addr  = 13'h0004;
    a_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    a_wr_addr = 13'h0000; a_wr_data = 32'hFFFFFFFF; a_wr_strb = 4'hF; a_wr_en = 1'b1;
    #2;
    checkOutput("abort rsp_valid in reset", 128'(a_rsp_valid), 128'd0);
    @(posedge clk); #1;
    a_wr_en = 1'b0; a_wr_strb = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput($sformatf("abort cycle %0d rsp_valid", c), 128'(a_rsp_valid), 128'd0);
      checkOutput($sformatf("abort cycle %0d req_ready", c), 128'(a_req_ready), 128'd1);
      @(posedge clk); #1;
    end
    applyStimulus(vecs[0], 100);

    // Zero-wait instance: response one cycle after accept, and read-before-write on capture.
    b_write(13'h0010, 32'hDEADBEEF, 4'hF);
    b_write(13'h0030, 32'h11223344, 4'hF);
    b_req_addr  = 13'h0010;
    b_req_valid = 1'b1;
    @(negedge clk);
    checkOutput("b pre-accept rsp_valid", 128'(b_rsp_valid), 128'd0);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    checkOutput("b T+1 rsp_valid", 128'(b_rsp_valid), 128'd1);
    checkOutput("b T+1 rsp_data", 128'(b_rsp_data), 128'(32'hDEADBEEF));
    checkOutput("b T+1 rsp_err", 128'(b_rsp_err), 128'd0);
    checkOutput("b T+1 req_ready", 128'(b_req_ready), 128'd0);
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("b idle rsp_valid", 128'(b_rsp_valid), 128'd0);
    checkOutput("b idle rsp_data", 128'(b_rsp_data), 128'd0);
    checkOutput("b idle req_ready", 128'(b_req_ready), 128'd1);
    @(posedge clk); #1;

    b_req_addr = 13'h0030; b_req_valid = 1'b1;
    b_wr_addr = 13'h0030; b_wr_data = 32'h0000AB00; b_wr_strb = 4'b0010; b_wr_en = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0; b_wr_en = 1'b0; b_wr_strb = 4'h0;
    @(negedge clk);
    checkOutput("b same-cycle rsp_data", 128'(b_rsp_data), 128'(32'h11223344));
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
    b_req_addr = 13'h0030; b_req_valid = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    checkOutput("b later rsp_valid", 128'(b_rsp_valid), 128'd1);
    checkOutput("b later rsp_data", 128'(b_rsp_data), 128'(32'h1122AB44));
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter IMEM_W, default 13: byte-address width; depth 2**(IMEM_W-2) 32-bit words.
REQ-002 Parameter WAIT_CYC, default 1: extra read wait states, legal range 0..15.
REQ-003 Parameter FETCH_N, default 1: words returned per request, legal values 1, 2, 4.
REQ-004 Port clk_i  input  1: single clock; all logic on its rising edge.
REQ-005 Port rst_ni  input  1: reset, asynchronous assert, active-low.
REQ-006 Port req_valid_i  input  1: fetch request valid.
REQ-007 Port req_ready_o  output  1: block accepts a request.
REQ-008 Port req_addr_i  input  IMEM_W: byte address of the first word.
REQ-009 Port rsp_valid_o  output  1: response valid.
REQ-010 Port rsp_ready_i  input  1: consumer accepts the response.
REQ-011 Port rsp_data_o  output  32*FETCH_N: word k in bits [32k+31:32k].
REQ-012 Port rsp_err_o  output  1: misaligned-request flag.
REQ-013 Port wr_en_i  input  1: loader write strobe.
REQ-014 Port wr_addr_i  input  IMEM_W: loader byte address; bits [1:0] ignored.
REQ-015 Port wr_data_i  input  32: loader write data.
REQ-016 Port wr_strb_i  input  4: byte enables; bit b enables byte b.

Function
REQ-017 FSM states: IDLE, WAIT, RESP.
REQ-018 req_ready_o SHALL be 1 only in IDLE.
REQ-019 Accept occurs at cycle T when req_valid_i and req_ready_o are both 1; the address is registered at T.
REQ-020 After accept: if WAIT_CYC=0, go to RESP; otherwise go to WAIT, with the counter loaded to WAIT_CYC-1.
REQ-021 WAIT decrements the counter each cycle and goes to RESP when it reads 0; rsp_valid_o SHALL first be 1 at cycle T+1+WAIT_CYC.
REQ-022 Read data SHALL be captured into a register on the transition into RESP, and held stable while in RESP.
REQ-023 RESP holds rsp_valid_o, rsp_data_o and rsp_err_o until rsp_ready_i=1, then goes to IDLE; the next accept is possible one cycle later.
REQ-024 Word k = mem[(req_addr_i[IMEM_W-1:2]+k) mod depth]: fetches past the top word wrap to word 0.
REQ-025 A write commits at the clock edge where wr_en_i=1, updating only strobed bytes; writes are legal in any state.
REQ-026 A write and a read capture of the same word in the same cycle SHALL return the old data (read-before-write).
REQ-027 rsp_data_o and rsp_err_o SHALL be 0 whenever rsp_valid_o=0.

Reset
REQ-028 With rst_ni=0: state=IDLE, counter=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, and req_ready_o=1 once rst_ni=1.
REQ-029 Reset mid-transaction SHALL abort it silently; no response is ever issued for it.
REQ-030 Memory contents SHALL NOT be cleared by reset; writes while rst_ni=0 SHALL be ignored.

Configuration
REQ-031 Macro IMEM_FETCH_ERR_EN defined: a request with req_addr_i[1:0]!=0 completes with the normal latency, rsp_err_o=1 and rsp_data_o=0.
REQ-032 Macro IMEM_FETCH_ERR_EN undefined: req_addr_i[1:0] is ignored, and rsp_err_o is tied to 0.

Structure
REQ-033 Package imem_pkg SHALL hold the FSM state enum, the 32-bit word typedef and the WAIT_CYC counter width (4 bits).
REQ-034 Storage SHALL be one sub-module, imem_array, with one byte-strobed write port and FETCH_N combinational read ports; imem_fetch holds the FSM, counter and response registers.

Verification
REQ-035 WAIT_CYC=0, FETCH_N=1: write 0xDEADBEEF at 0x10, request 0x10 accepted at T -> rsp_valid_o=1 at T+1, data 0xDEADBEEF.
REQ-036 WAIT_CYC=3: request accepted at T, rsp_ready_i=0 until T+7 -> rsp_valid_o=1 from T+4 through T+7 with stable data; req_ready_o=1 at T+8.
REQ-037 FETCH_N=4, IMEM_W=13: request 0x1FF8 -> words from 0x1FF8, 0x1FFC, 0x0000, 0x0004 in slices 0..3.
REQ-038 wr_strb_i=4'b0010, data 0x0000AB00 onto word 0x11223344 -> a later read returns 0x1122AB44; a same-cycle read capture returns 0x11223344.
REQ-039 With IMEM_FETCH_ERR_EN: request 0x0006 -> rsp_err_o=1, rsp_data_o=0; without the macro -> data of word 0x0004, rsp_err_o=0.
REQ-040 rst_ni pulsed low during WAIT -> no rsp_valid_o for that request; req_ready_o=1 after release; previously written memory data still readable.
